// File: rtl/uart_tx_ex.sv
// UART transmitter that takes words from a valid/ready byte stream.
// Parity and stop-bit count are chosen per frame; an idle gap can follow the last word of a packet.
module uart_tx_ex #(
  parameter int clk_rate = 100000000,
  parameter int Baud     = 115200,
  parameter int Word_len = 8,
  parameter int GAP_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Word_len-1:0] tx_data,
  input  logic                tx_data_valid,
  input  logic                tx_data_last,
  input  logic [1:0]          parity_mode,
  input  logic                two_stop,
  output logic                tx_data_ready,
  output logic                Uart_tx,
  output logic                tx_busy,
  output logic                frame_done
);

  localparam int DIV      = clk_rate / Baud;
  localparam int BAUD_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
  localparam int CNT_MAX  = (Word_len - 1 > GAP_LAST) ? Word_len - 1 : GAP_LAST;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_ex: clk_rate/Baud must be at least 2");
  end
  if (Word_len < 5 || Word_len > 9) begin : g_bad_word_len
    $error("uart_tx_ex: Word_len must be in 5..9");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [Word_len-1:0] shift_q, shift_d;
  logic                last_q, last_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                two_stop_q, two_stop_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                baud_end;
  logic                transfer;

  assign tx_data_ready = (state_q == IDLE) && !rst;
  assign tx_busy       = (state_q != IDLE) && !rst;
  assign transfer      = tx_data_valid && tx_data_ready;
  assign baud_end      = (baud_q == BAUD_W'(DIV - 1));
  assign Uart_tx       = tx_q;
  assign frame_done    = done_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d    = START;
          baud_d     = '0;
          cnt_d      = '0;
          shift_d    = tx_data;
          last_d     = tx_data_last;
          two_stop_d = two_stop;
          par_en_d   = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          // Odd parity inverts the XOR so the ones count including parity is odd.
          par_bit_d  = (parity_mode == 2'd1) ? ~^tx_data : ^tx_data;
        end
      end
      START: begin
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (cnt_q == CNT_W'(Word_len - 1)) begin
            cnt_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (two_stop_q && (cnt_q == '0)) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (last_q && (GAP_BITS > 0)) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (baud_end) begin
          if (cnt_q == CNT_W'(GAP_LAST)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line register is loaded with the level of the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ex.sv
// Randomised self-checking bench for uart_tx_ex at DIV=16, 8-bit words, 2-bit packet gap.
// Expected line waveforms are built as a list of bit levels, each held DIV cycles.
module tb_uart_tx_ex;

  localparam int CLK_RATE = 1600;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_RATE / BAUD;
  localparam int WORD_LEN = 8;
  localparam int GAP      = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [WORD_LEN-1:0] txData;
  logic                txDataValid;
  logic                txDataLast;
  logic [1:0]          parityMode;
  logic                twoStop;
  logic                txDataReady;
  logic                uartTx;
  logic                txBusy;
  logic                frameDone;

  int compareCount  = 0;
  int mismatchCount = 0;

  uart_tx_ex #(
    .clk_rate(CLK_RATE),
    .Baud(BAUD),
    .Word_len(WORD_LEN),
    .GAP_BITS(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(txData),
    .tx_data_valid(txDataValid),
    .tx_data_last(txDataLast),
    .parity_mode(parityMode),
    .two_stop(twoStop),
    .tx_data_ready(txDataReady),
    .Uart_tx(uartTx),
    .tx_busy(txBusy),
    .frame_done(frameDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic presentWord(input logic [7:0] d, input logic [1:0] pm, input logic ts, input logic lst);
    txData      = d;
    parityMode  = pm;
    twoStop     = ts;
    txDataLast  = lst;
    txDataValid = 1'b1;
  endtask

  // Called at a falling edge with a word presented. Returns at the falling edge where the
  // block is back in IDLE. When keepValid is set the next word is presented mid-frame.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                               input logic lst, input bit keepValid, input logic [7:0] nd,
                               input logic [1:0] npm, input logic nts, input logic nlst);
    bit expQ[$];
    int ones;
    int total;
    int waitCnt;
    expQ.push_back(1'b0);
    for (int i = 0; i < WORD_LEN; i++) expQ.push_back(d[i]);
    ones = $countones(d);
    if (pm == 2'd1) expQ.push_back(bit'((ones % 2) == 0));
    else if (pm == 2'd2) expQ.push_back(bit'((ones % 2) == 1));
    expQ.push_back(1'b1);
    if (ts) expQ.push_back(1'b1);
    if (lst) for (int g = 0; g < GAP; g++) expQ.push_back(1'b1);
    total = expQ.size() * DIV;

    waitCnt = 0;
    while (!txDataReady && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!txDataReady) begin
      checkOutput("ready_timeout", {31'd0, txDataReady}, 32'd1);
      txDataValid = 1'b0;
      return;
    end
    @(negedge clk);
    if (keepValid) begin
      presentWord(nd, npm, nts, nlst);
    end else begin
      txDataValid = 1'b0;
      txData      = WORD_LEN'($urandom);
      parityMode  = 2'($urandom_range(0, 3));
      twoStop     = 1'($urandom);
      txDataLast  = 1'($urandom);
    end
    for (int k = 0; k < total; k++) begin
      checkOutput("line", {31'd0, uartTx}, {31'd0, expQ[k / DIV]});
      checkOutput("done_mid", {31'd0, frameDone}, 32'd0);
      checkOutput("ready_mid", {31'd0, txDataReady}, 32'd0);
      checkOutput("busy_mid", {31'd0, txBusy}, 32'd1);
      @(negedge clk);
    end
    checkOutput("done_end", {31'd0, frameDone}, 32'd1);
    checkOutput("ready_end", {31'd0, txDataReady}, 32'd1);
    checkOutput("busy_end", {31'd0, txBusy}, 32'd0);
    checkOutput("line_end", {31'd0, uartTx}, 32'd1);
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_line", {31'd0, uartTx}, 32'd1);
      checkOutput("idle_done", {31'd0, frameDone}, 32'd0);
      checkOutput("idle_ready", {31'd0, txDataReady}, 32'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d, nd;
    logic [1:0] pm, npm;
    logic       ts, nts, lst, nlst;
    bit         keep;

    rst = 1'b1;
    txDataValid = 1'b0;
    txData = '0;
    txDataLast = 1'b0;
    parityMode = 2'd0;
    twoStop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_line", {31'd0, uartTx}, 32'd1);
      checkOutput("rst_ready", {31'd0, txDataReady}, 32'd0);
      checkOutput("rst_busy", {31'd0, txBusy}, 32'd0);
      checkOutput("rst_done", {31'd0, frameDone}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'd0, txDataReady}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, txBusy}, 32'd0);

    // Directed frames: 8N1, parity variants, two stop bits with packet gap.
    presentWord(8'hA5, 2'd0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    presentWord(8'hA5, 2'd2, 1'b0, 1'b0);
    applyStimulus(8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    presentWord(8'hA5, 2'd1, 1'b0, 1'b0);
    applyStimulus(8'hA5, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    presentWord(8'h07, 2'd2, 1'b0, 1'b0);
    applyStimulus(8'h07, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    presentWord(8'hA5, 2'd3, 1'b0, 1'b0);
    applyStimulus(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    presentWord(8'h3C, 2'd0, 1'b1, 1'b1);
    applyStimulus(8'h3C, 2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    idleCheck(4);

    // Back-to-back with valid held; parity mode changes while the first frame is in flight.
    presentWord(8'h55, 2'd0, 1'b0, 1'b0);
    applyStimulus(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd2, 1'b0, 1'b0);
    applyStimulus(8'hAA, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    idleCheck(3 * DIV);

    // Abort at cycle 70 of a frame, then a fresh word.
    presentWord(8'hF0, 2'd1, 1'b1, 1'b1);
    @(negedge clk);
    txDataValid = 1'b0;
    for (int k = 0; k < 70; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_line", {31'd0, uartTx}, 32'd1);
    checkOutput("abort_done", {31'd0, frameDone}, 32'd0);
    checkOutput("abort_ready", {31'd0, txDataReady}, 32'd0);
    checkOutput("abort_busy", {31'd0, txBusy}, 32'd0);
    rst = 1'b0;
    idleCheck(2 * DIV);
    presentWord(8'h81, 2'd0, 1'b0, 1'b0);
    applyStimulus(8'h81, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

    // Random frames, some chained with valid held across the boundary.
    d   = 8'($urandom);
    pm  = 2'($urandom_range(0, 3));
    ts  = 1'($urandom);
    lst = 1'($urandom);
    presentWord(d, pm, ts, lst);
    for (int r = 0; r < 12; r++) begin
      keep = (r < 11) ? bit'($urandom_range(0, 1)) : 1'b0;
      nd   = 8'($urandom);
      npm  = 2'($urandom_range(0, 3));
      nts  = 1'($urandom);
      nlst = 1'($urandom);
      applyStimulus(d, pm, ts, lst, keep, nd, npm, nts, nlst);
      if (keep) begin
        d = nd; pm = npm; ts = nts; lst = nlst;
      end else begin
        d   = 8'($urandom);
        pm  = 2'($urandom_range(0, 3));
        ts  = 1'($urandom);
        lst = 1'($urandom);
        if (r < 11) presentWord(d, pm, ts, lst);
      end
    end
    idleCheck(DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
